// File: rtl/ulv_shift_engine_if.sv
// Bus bundle for ulv_shift_engine: op strobe, operands, serial inputs and register/status outputs.
// The parameters must match the engine instance attached to the slave modport.
interface ulv_shift_engine_if #(
    parameter int N  = 8,
    parameter int S  = 1,
    parameter int CW = $clog2(N + 1)
) ();
    logic          en;
    logic [2:0]    ctrl;
    logic [N-1:0]  d;
    logic [S-1:0]  sin_l;
    logic [S-1:0]  sin_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  q;
    logic [S-1:0]  sout_l;
    logic [S-1:0]  sout_r;
    logic          busy;
    logic          done;

    modport master (
        output en, ctrl, d, sin_l, sin_r, cnt,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, ctrl, d, sin_l, sin_r, cnt,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/ulv_shift_engine.sv
// Universal S-bit-step shift register with single-cycle ops and a burst mode that
// loads a word and then shifts it right once per cycle for a programmed count.
module ulv_shift_engine #(
    parameter int N = 8,
    parameter int S = 1
) (
    input  logic              clk,
    input  logic              reset,
    ulv_shift_engine_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_BURST = 3'b111;

    state_t        state_q;
    logic [N-1:0]  q_q;
    logic [CW-1:0] rem_q;
    logic          busy_q;
    logic          done_q;

    logic [N-1:0]  shl_d;
    logic [N-1:0]  shr_d;
    logic [N-1:0]  rol_d;
    logic [N-1:0]  ror_d;
    logic [N-1:0]  asr_d;

    // Shift candidates; the burst RUN step reuses the SHR path with sin_r.
    always_comb begin
        shl_d = {q_q[N-S-1:0], bus.sin_l};
        shr_d = {bus.sin_r, q_q[N-1:S]};
        rol_d = {q_q[N-S-1:0], q_q[N-1 -: S]};
        ror_d = {q_q[S-1:0], q_q[N-1:S]};
        asr_d = {{S{q_q[N-1]}}, q_q[N-1:S]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        case (bus.ctrl)
                            OP_HOLD:  q_q <= q_q;
                            OP_SHL:   q_q <= shl_d;
                            OP_SHR:   q_q <= shr_d;
                            OP_LOAD:  q_q <= bus.d;
                            OP_ROL:   q_q <= rol_d;
                            OP_ROR:   q_q <= ror_d;
                            OP_ASR:   q_q <= asr_d;
                            OP_BURST: begin
                                q_q   <= bus.d;
                                rem_q <= bus.cnt;
                                // A zero-length burst skips RUN and signals completion at once.
                                if (bus.cnt == '0) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= RUN;
                                    busy_q  <= 1'b1;
                                end
                            end
                            default:  q_q <= q_q;
                        endcase
                    end
                end
                RUN: begin
                    q_q   <= shr_d;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[N-1 -: S];
    assign bus.sout_r = q_q[S-1:0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
